// File: rtl/fifo_stream_reader.sv
// Purpose : pops words from a synchronous FIFO and presents them as a valid/ready
//           stream. Beats are grouped into BURST_LEN-beat bursts, and m_last marks
//           the final beat of each burst.
// Latency : a read accepted at edge N is captured at edge N+1 and is visible on
//           m_* after that edge. At steady state the block moves 1 word per clock.
// Backpr. : there are two buffer credits. A FIFO read issues only when the word
//           has a guaranteed slot. m_* hold steady while m_valid && !m_ready.
//
// Ports   : clk, rst_n (async, active low), enable, fifo_empty, fifo_dout,
//           fifo_rd_en, m_valid, m_ready, m_data, m_last, busy,
//           word_count (only when FIFO_READER_STATS_EN is defined).
// Option  : define FIFO_READER_STATS_EN to add the word_count pop counter.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_count
`endif
);

  localparam int            BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);

  // Parameter sanity: a one-beat burst would make m_last meaningless.
  if (BURST_LEN < 2 || CNT_WIDTH < 1) begin : g_bad_params
    $error("fifo_stream_reader: BURST_LEN must be >= 2 and CNT_WIDTH >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                state;
  logic [1:0]            occ;          // buffer occupancy, 0..2
  logic                  inflight;     // a read was accepted last cycle
  logic [BW-1:0]         issue_cnt;
  logic [BW-1:0]         beat_cnt;
  logic [DATA_WIDTH-1:0] buf0;         // head of the buffer
  logic [DATA_WIDTH-1:0] buf1;

  logic       pop;
  logic       permit;
  logic       last_issue;
  logic [1:0] credit_used;

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf0;
  assign m_last  = m_valid && (beat_cnt == LAST_IDX);
  assign busy    = (state != IDLE) || (occ != 2'd0) || inflight;

  always_comb begin
    pop         = m_valid && m_ready;
    credit_used = occ + {1'b0, inflight};
    permit      = 1'b0;
    case (state)
      // With enable low and no burst open, the block stays quiet so that it
      // never opens a burst it would have to finish after being told to stop.
      RUN:     permit = enable || (issue_cnt != '0);
      STOP:    permit = 1'b1;
      default: permit = 1'b0;
    endcase
    // A slot freed by a pop this cycle can be reused by a read this cycle.
    fifo_rd_en = permit && !fifo_empty &&
                 ((credit_used < 2'd2) || ((credit_used == 2'd2) && pop));
    last_issue = fifo_rd_en && (issue_cnt == LAST_IDX);
  end

  // Control FSM and burst counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;

      if (fifo_rd_en) begin
        issue_cnt <= (issue_cnt == LAST_IDX) ? '0 : issue_cnt + 1'b1;
      end
      if (pop) begin
        beat_cnt <= (beat_cnt == LAST_IDX) ? '0 : beat_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          // If the final read of a burst is accepted in the same cycle that
          // enable drops, the burst is complete, so the FSM goes straight to IDLE.
          if (!enable) begin
            state <= ((issue_cnt == '0) || last_issue) ? IDLE : STOP;
          end
        end
        STOP: begin
          if (enable)          state <= RUN;
          else if (last_issue) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry output buffer. The in-flight word lands this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_dout;
          else             buf1 <= fifo_dout;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Capture and pop together: occupancy holds, and the head advances.
          if (occ == 2'd2) begin
            buf0 <= buf1;
            buf1 <= fifo_dout;
          end else begin
            buf0 <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   word_count <= '0;
    else if (pop) word_count <= word_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout  = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
`ifdef FIFO_READER_STATS_EN
  logic [CW-1:0] word_count;
`endif

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .word_count (word_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
  } beat_t;

  int    tests = 0;
  int    fails = 0;
  int    fifo_q[$];   // FIFO contents
  int    push_q[$];   // writes that land at the next edge
  int    exp_q[$];    // words still owed to the sink, in order
  beat_t got_q[$];    // beats observed at the sink
  int    reads_acc  = 0;
  int    beats_done = 0;
  bit    prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int    mon_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural FIFO model: reads return data on the next edge.
  always @(posedge clk) begin
    if (!rst_n) reads_acc = 0;
    if (fifo_rd_en && !fifo_empty && fifo_q.size() > 0) begin
      fifo_dout <= DW'(fifo_q.pop_front());
      if (rst_n) reads_acc++;
    end
    while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Sink-side scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      // Reset discards buffered and in-flight words but leaves the FIFO untouched.
      beats_done = 0;
      prev_stall = 1'b0;
      exp_q      = {fifo_q, push_q};
    end else begin
      check("rd_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
      check("occupancy_le_2", {31'd0, (reads_acc - beats_done) <= 2}, 32'd1);
      check("last_without_valid", {31'd0, m_last & ~m_valid}, 32'd0);
`ifdef FIFO_READER_STATS_EN
      check("word_count", {16'd0, word_count}, 32'(beats_done % (1 << CW)));
`endif
      if (prev_stall) begin
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", {24'd0, m_data}, {24'd0, prev_data});
        check("stall_last", {31'd0, m_last}, {31'd0, prev_last});
      end
      if (m_valid && m_ready) begin
        check("beat_owed", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("beat_data", {24'd0, m_data}, 32'(mon_exp));
        end
        check("beat_last", {31'd0, m_last}, {31'd0, (beats_done % BL) == BL - 1});
        got_q.push_back('{data: int'(m_data), last: m_last});
        beats_done++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    push_q.push_back(v);
    exp_q.push_back(v);
  endtask

  // Check that got_q equals base, base+10, ..., with m_last only at index last_at.
  task automatic check_got(input string tag, input int base, input int n, input int last_at);
    check({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check({tag, "_data"}, 32'(got_q[i].data), 32'(base + 10 * i));
      check({tag, "_last"}, {31'd0, got_q[i].last}, {31'd0, i == last_at});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},  {31'd0, fifo_rd_en}, 32'd0);
    check({tag, "_valid"},  {31'd0, m_valid},    32'd0);
    check({tag, "_data"},   {24'd0, m_data},     32'd0);
    check({tag, "_last"},   {31'd0, m_last},     32'd0);
    check({tag, "_busy"},   {31'd0, busy},       32'd0);
`ifdef FIFO_READER_STATS_EN
    check({tag, "_wcount"}, {16'd0, word_count}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic rd_s[8];
    logic v_s[8];
    logic l_s[8];
    logic [DW-1:0] d_s[8];
    int   rd_cnt;
    int   waited;

    rst_n   = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // 1) Preloaded 10..40, sink always ready: back-to-back reads and beats.
    got_q.delete();
    for (int i = 1; i <= 4; i++) push(10 * i);
    enable  = 1'b1;
    m_ready = 1'b1;
    step();  // this edge enters RUN and loads the FIFO
    for (int i = 0; i < 8; i++) begin
      rd_s[i] = fifo_rd_en;
      v_s[i]  = m_valid;
      d_s[i]  = m_data;
      l_s[i]  = m_last;
      step();
    end
    for (int i = 0; i < 6; i++) check("t1_rd_en", {31'd0, rd_s[i]}, {31'd0, i < 4});
    check("t1_valid0", {31'd0, v_s[0]}, 32'd0);
    check("t1_valid1", {31'd0, v_s[1]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t1_stream_valid", {31'd0, v_s[2 + i]}, 32'd1);
      check("t1_stream_data",  {24'd0, d_s[2 + i]}, 32'(10 * (i + 1)));
      check("t1_stream_last",  {31'd0, l_s[2 + i]}, {31'd0, i == 3});
    end
    check_got("t1", 10, 4, 3);
`ifdef FIFO_READER_STATS_EN
    check("t1_word_count", {16'd0, word_count}, 32'd4);
`endif
    enable = 1'b0;
    step();
    step();
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // 2) Same data with the sink toggling ready every cycle.
    got_q.delete();
    for (int i = 1; i <= 4; i++) push(10 * i);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    check_got("t2", 10, 4, 3);
    enable  = 1'b0;
    m_ready = 1'b1;
    step();
    step();
    step();
    check("t2_busy_idle", {31'd0, busy}, 32'd0);

    // 3) FIFO runs dry mid-burst. The burst stays open until more data arrives.
    got_q.delete();
    push(10);
    push(20);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check_got("t3_partial", 10, 2, -1);
    check("t3_busy", {31'd0, busy}, 32'd1);
    check("t3_valid_dropped", {31'd0, m_valid}, 32'd0);
    push(30);
    push(40);
    for (int i = 0; i < 8; i++) step();
    check_got("t3_resume", 10, 4, 3);
    enable = 1'b0;
    step();
    step();
    step();
    check("t3_busy_idle", {31'd0, busy}, 32'd0);

    // 4) Enable drops after the second read. The burst finishes, and 50.. stays queued.
    got_q.delete();
    for (int i = 1; i <= 8; i++) push(10 * i);
    enable = 1'b1;
    step();
    rd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (fifo_rd_en) rd_cnt++;
      if (i == 2) enable = 1'b0;  // reads of 10 and 20 already accepted
      step();
    end
    check("t4_reads", 32'(rd_cnt), 32'd4);
    check_got("t4", 10, 4, 3);
    check("t4_busy_idle", {31'd0, busy}, 32'd0);
    check("t4_fifo_left", 32'(fifo_q.size()), 32'd4);

    // 5) Reset mid-burst: 50 is in flight when reset hits, and 60 is still in the FIFO.
    got_q.delete();
    enable = 1'b1;
    step();  // enter RUN
    step();  // read of 50 accepted
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    step();
    step();
    check_reset_outputs("t5_held");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    push(90);
    for (int i = 0; i < 6; i++) step();
    check_got("t5", 60, 4, 3);

    // 6) Random traffic against the scoreboard, followed by a clean drain.
    got_q.delete();
    for (int i = 0; i < 1500; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if (fifo_q.size() + push_q.size() < 12 && $urandom_range(0, 2) == 0)
        push(int'($urandom_range(0, 255)));
      if ($urandom_range(0, 39) == 0) enable = !enable;
      step();
    end
    enable  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < BL; i++) push(int'($urandom_range(0, 255)));
    waited = 0;
    while (busy && waited < 300) begin
      step();
      waited++;
    end
    step();
    check("t6_drain_done", {31'd0, busy}, 32'd0);
    check("t6_whole_bursts", 32'(beats_done % BL), 32'd0);
    check("t6_no_loss_dup", 32'(exp_q.size()), 32'(fifo_q.size() + push_q.size()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for `synchronous_fifo`: pops words from the FIFO read port and presents them on a valid/ready stream, grouping beats into fixed-length bursts marked by `m_last`. Absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer, sustaining one word per clock while the FIFO is non-empty and the sink is ready. Sits between the FIFO and any downstream consumer.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `BURST_LEN`, 4, beats per burst; must be ≥ 2.
- `CNT_WIDTH`, 16, width of the statistics counter (used only with the configuration macro).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  start/continue issuing FIFO reads.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  sink accepts the word.
- `m_data`  out  DATA_WIDTH  output word.
- `m_last`  out  1  last beat of the burst.
- `busy`  out  1  state ≠ IDLE, or buffer/in-flight data present.
- `word_count`  out  CNT_WIDTH  accepted beats (only with FIFO_READER_STATS_EN).

## Operation
- A read is accepted when `fifo_rd_en && !fifo_empty`. `fifo_rd_en` is never asserted while `fifo_empty` is 1.
- `inflight` (0/1) is set on an accepted read, and the word is written into the buffer on the next edge.
- `occ` (0..2) is the buffer occupancy. A pop is `m_valid && m_ready`; `m_valid = occ != 0`; `m_data` is the head word.
- Credit rule: `fifo_rd_en` = issue permission && `!fifo_empty` && (`occ + inflight < 2`, or `== 2` with a pop this cycle). The buffer never overflows.
- `issue_cnt` (0..BURST_LEN-1) counts reads issued in the current burst and wraps to 0 after BURST_LEN-1.
- `beat_cnt` (0..BURST_LEN-1) counts popped beats and wraps likewise. `m_last = m_valid && beat_cnt == BURST_LEN-1`.
- FSM:
  - IDLE: no reads. `enable` = 1 → RUN.
  - RUN: reads are issued per the credit rule.
    - `enable` = 0 with `issue_cnt` = 0 → IDLE.
    - `enable` = 0 with `issue_cnt` ≠ 0 → STOP.
  - STOP: reads continue until the burst's final read (`issue_cnt` = BURST_LEN-1) is accepted, then → IDLE. `enable` re-asserted in STOP → RUN.
- Bursts are never truncated. If the FIFO runs empty mid-burst, the block waits. `m_valid` drops, and `m_last` is not asserted until the BURST_LEN-th beat.
- Buffered and in-flight words always drain to the sink, including in IDLE.
- Data order equals FIFO order. No word is lost or duplicated under any `m_ready` pattern.

## Timing
- Reset (`rst_n` = 0, asynchronous):
  - State → IDLE; `occ`, `inflight`, `issue_cnt`, `beat_cnt` → 0.
  - Outputs: `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0, `m_last` = 0, `busy` = 0, `word_count` = 0.
  - Data in flight is discarded. Reset mid-burst loses the partial burst; the FIFO contents are untouched.
- Latency: read accepted at edge N → word captured at edge N+1 → `m_valid` high after edge N+1 (buffer empty, sink ready).
- Throughput: 1 word/clk steady state with `m_ready` held at 1.
- `m_valid`/`m_data`/`m_last` are stable while `m_valid && !m_ready`.
- `fifo_rd_en` is combinational from state, counters, `fifo_empty` and `m_ready`. There is no combinational path from `fifo_dout` to any output.
- Simultaneous capture and pop: `occ` unchanged, and the head advances.
- `enable` rising in IDLE: the first read can issue in the cycle after the edge that enters RUN.

## Configuration
- `FIFO_READER_STATS_EN` defined: the `word_count` port exists.
  - It increments by 1 on every pop and wraps modulo 2^CNT_WIDTH.
  - It resets to 0.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- FIFO preloaded with 10,20,30,40; `enable` = 1; `m_ready` = 1:
  - `fifo_rd_en` is high for 4 consecutive cycles.
  - `m_data` is 10,20,30,40 on consecutive cycles, with `m_last` only on 40.
  - With stats enabled, `word_count` = 4.
- Same data with `m_ready` toggling 1,0,1,0:
  - Order is 10,20,30,40 with no drops or duplicates.
  - `m_data` is held while stalled, and `occ` never exceeds 2.
- FIFO holds 10,20 only; `enable` = 1:
  - Two beats appear without `m_last`, and `busy` = 1.
  - Push 30,40 later: beats resume, and `m_last` is on 40.
- `enable` dropped after the second read of a burst of 10..80:
  - Exactly 4 beats are read (10..40), ending with `m_last`, then IDLE.
  - No read is issued for 50, and `busy` returns to 0.
- `rst_n` pulsed low mid-burst: all outputs are 0 immediately, with no clock needed.
  - After release with `enable` = 1, the next FIFO word is emitted as beat 0 of a new burst.
